// File: rtl/puf_key_recon_ctrl.sv
// rtl/puf_key_recon_ctrl.sv - sequences a Hamming(15,11) decoder to rebuild a PUF key
module puf_key_recon_ctrl #(
    parameter  int NUM_WORDS = 4,
    parameter  int MAX_CORR  = 4,
    localparam int KEY_W     = 11 * NUM_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cw_valid,
    output logic             cw_ready,
    input  logic [14:0]      cw_data,
    output logic [14:0]      dec_cw,
    output logic             dec_enable,
    input  logic [10:0]      dec_data,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic [7:0]       corr_count,
    output logic             fail
);

    localparam int                IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0]  L_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]        L_MAX  = 8'(MAX_CORR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_CW,
        S_DECODE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [14:0]        r_dec_cw;
    logic [KEY_W-1:0]   r_key;
    logic [7:0]         r_corr;
    logic               r_key_valid;
    logic               r_fail;
    logic [10:0]        w_raw;

    // Data bits sit at the non-power-of-two codeword positions.
    assign w_raw = {r_dec_cw[14:8], r_dec_cw[6:4], r_dec_cw[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_WAIT_CW;
            S_WAIT_CW: if (cw_valid) w_next = S_DECODE;
            S_DECODE:  w_next = (r_idx == L_LAST) ? S_DONE : S_WAIT_CW;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_dec_cw    <= '0;
            r_key       <= '0;
            r_corr      <= '0;
            r_key_valid <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_key       <= '0;
                        r_corr      <= '0;
                        r_key_valid <= 1'b0;
                        r_fail      <= 1'b0;
                    end
                end
                S_WAIT_CW: begin
                    if (cw_valid) begin
                        r_dec_cw <= cw_data;
                    end
                end
                S_DECODE: begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_key[k*11 +: 11] <= dec_data;
                        end
                    end
                    // Parity-only corrections leave the data bits equal to raw.
                    if ((dec_data != w_raw) && (r_corr != 8'hFF)) begin
                        r_corr <= r_corr + 8'd1;
                    end
                    if (r_idx != L_LAST) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_key_valid <= 1'b1;
                    r_fail      <= (r_corr > L_MAX);
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign cw_ready   = (r_state == S_WAIT_CW);
    assign dec_enable = (r_state == S_DECODE);
    assign dec_cw     = r_dec_cw;
    assign key_out    = r_key;
    assign key_valid  = r_key_valid;
    assign corr_count = r_corr;
    assign fail       = r_fail;

endmodule

// File: tb/tb_puf_key_recon_ctrl.sv
// tb/tb_puf_key_recon_ctrl.sv - randomized self-checking bench for puf_key_recon_ctrl
module tb_puf_key_recon_ctrl;

    localparam int NW       = 4;
    localparam int MAXC     = 2;
    localparam int KW       = 11 * NW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cw_valid = 1'b0;
    logic          cw_ready;
    logic [14:0]   cw_data = '0;
    logic [14:0]   dec_cw;
    logic          dec_enable;
    logic [10:0]   dec_data = '0;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic [7:0]    corr_count;
    logic          fail;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    puf_key_recon_ctrl #(.NUM_WORDS(NW), .MAX_CORR(MAXC)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .cw_data    (cw_data),
        .dec_cw     (dec_cw),
        .dec_enable (dec_enable),
        .dec_data   (dec_data),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .corr_count (corr_count),
        .fail       (fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int syndrome(input logic [14:0] c);
        int s = 0;
        for (int i = 0; i < 15; i++) if (c[i]) s ^= (i + 1);
        return s;
    endfunction

    function automatic logic [10:0] extract(input logic [14:0] c);
        int dp[11] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = c[dp[j]];
        return d;
    endfunction

    function automatic logic [14:0] encode(input logic [10:0] d);
        int dp[11] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
        logic [14:0] c = '0;
        int s;
        for (int j = 0; j < 11; j++) c[dp[j]] = d[j];
        s = syndrome(c);
        for (int b = 0; b < 4; b++) if (s[b]) c[(1 << b) - 1] = 1'b1;
        return c;
    endfunction

    function automatic logic [10:0] hdec(input logic [14:0] c);
        int s = syndrome(c);
        if (s != 0) c[s-1] = ~c[s-1];
        return extract(c);
    endfunction

    function automatic bit is_data_pos(input int p);
        return (p >= 0) && (p != 0) && (p != 1) && (p != 3) && (p != 7);
    endfunction

    // External decoder: responds only while enabled, holds otherwise.
    always @(dec_enable or dec_cw) if (dec_enable) dec_data = hdec(dec_cw);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_recon(input logic [10:0] d[NW], input int fp[NW],
                             input int max_gap, input bit chk_lat);
        logic [KW-1:0] exp_key;
        logic [14:0]   cw;
        int            exp_corr = 0;
        int            n, gap, t0;
        for (int k = 0; k < NW; k++) begin
            exp_key[k*11 +: 11] = d[k];
            if (is_data_pos(fp[k])) exp_corr++;
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
        check("busy_after_start", busy, 1'b1);
        check("keyv_cleared", key_valid, 1'b0);
        for (int k = 0; k < NW; k++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (gap > 0) begin
                cw_valid = 1'b0;
                repeat (gap) begin
                    start   = 1'($urandom_range(0, 1));
                    cw_data = 15'($urandom);
                    @(negedge clk);
                end
                start = 1'b0;
            end
            cw = encode(d[k]);
            if (fp[k] >= 0) cw[fp[k]] = ~cw[fp[k]];
            cw_data  = cw;
            cw_valid = 1'b1;
            n = 0;
            while (!cw_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("ready_timeout", n < 20, 1'b1);
            check("dec_en_idle_wait", dec_enable, 1'b0);
            @(negedge clk);
            check("dec_en_decode", dec_enable, 1'b1);
            check("ready_decode", cw_ready, 1'b0);
            check("dec_cw", dec_cw, cw);
        end
        cw_valid = 1'($urandom_range(0, 1));
        n = 0;
        while (!key_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("keyv_timeout", n < 10, 1'b1);
        if (chk_lat) check("latency", cyc - t0 + 1, 2 * NW + 2);
        check("key_out", key_out, exp_key);
        check("corr_count", corr_count, exp_corr);
        check("fail", fail, exp_corr > MAXC);
        check("busy_idle", busy, 1'b0);
        cw_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("key_hold", key_out, exp_key);
        check("keyv_hold", key_valid, 1'b1);
        check("ready_idle", cw_ready, 1'b0);
        cw_valid = 1'b0;
    endtask

    initial begin
        logic [10:0] d[NW];
        int          fp[NW];

        repeat (3) @(negedge clk);
        check("rst_key", key_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cw_ready, 1'b0);
        check("rst_corr", corr_count, 8'd0);
        check("rst_keyv", key_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        d = '{11'h000, 11'h7FF, 11'h7FF, 11'h000};
        fp = '{-1, -1, -1, -1};
        run_recon(d, fp, 0, 1'b1);
        fp = '{-1, 6, -1, -1};
        run_recon(d, fp, 0, 1'b1);
        fp = '{0, -1, -1, -1};
        run_recon(d, fp, 0, 1'b1);
        fp = '{-1, -1, -1, -1};
        run_recon(d, fp, 3, 1'b0);
        fp = '{2, 6, -1, 14};
        run_recon(d, fp, 0, 1'b1);

        // Mid-run reset: two words accepted, then asynchronous clear.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cw_data  = encode(11'h7FF);
            cw_valid = 1'b1;
            while (!cw_ready) @(negedge clk);
            @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_key", key_out, '0);
        check("mid_rst_deccw", dec_cw, 15'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", cw_ready, 1'b0);
        check("mid_rst_decen", dec_enable, 1'b0);
        check("mid_rst_corr", corr_count, 8'd0);
        check("mid_rst_flags", {key_valid, fail}, 2'b00);
        cw_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        d = '{11'h123, 11'h456, 11'h789, 11'h2AB};
        fp = '{-1, 3, 9, -1};
        run_recon(d, fp, 1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < NW; k++) begin
                d[k]  = 11'($urandom);
                fp[k] = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
            end
            run_recon(d, fp, (r % 2 == 0) ? 0 : 3, (r % 2 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
